apb_gpio_multi: RTL

- Parametrised next-generation APB GPIO slave on the MCU peripheral bus, reached from the APB interconnect's GPIO port.
- Generalises the fixed GPIO to NUM_GPIO pins, with per-pin direction and atomic set/clear of outputs.
- Per-pin interrupts are selectable as level or edge, with configurable polarity.
- An optional per-pin debounce filter sits on the inputs; one aggregated interrupt line goes to the event unit.

---
 rtl/apb_gpio_multi.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/apb_gpio_multi.sv
// apb_gpio_multi: parametrised APB GPIO slave with per-pin direction,
// atomic set/clear of outputs and level/edge interrupts.
// Optional input debounce filter is built when GPIO_DEBOUNCE_EN is defined;
// without it the filter is bypassed and offset 0x24 is unmapped.
module apb_gpio_multi #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_GPIO       = 32,
  parameter int DB_CNT_WIDTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic [NUM_GPIO-1:0]       gpio_dir,
  output logic                      interrupt
);

  localparam int WORD_W = APB_ADDR_WIDTH - 2;

  localparam logic [WORD_W-1:0] OFF_DIR    = WORD_W'(0);
  localparam logic [WORD_W-1:0] OFF_IN     = WORD_W'(1);
  localparam logic [WORD_W-1:0] OFF_OUT    = WORD_W'(2);
  localparam logic [WORD_W-1:0] OFF_SET    = WORD_W'(3);
  localparam logic [WORD_W-1:0] OFF_CLR    = WORD_W'(4);
  localparam logic [WORD_W-1:0] OFF_EN     = WORD_W'(5);
  localparam logic [WORD_W-1:0] OFF_TYPE   = WORD_W'(6);
  localparam logic [WORD_W-1:0] OFF_POL    = WORD_W'(7);
  localparam logic [WORD_W-1:0] OFF_STATUS = WORD_W'(8);
`ifdef GPIO_DEBOUNCE_EN
  localparam logic [WORD_W-1:0] OFF_THRESH = WORD_W'(9);
`endif

  logic [NUM_GPIO-1:0] r_dir, r_out, r_intEn, r_intType, r_intPol, r_intStatus;
  logic [NUM_GPIO-1:0] r_sync1, r_sync2, r_filt, r_prev;
  logic                r_irq;

  logic [WORD_W-1:0]   w_word;
  logic                w_access, w_write, w_mapped;
  logic [NUM_GPIO-1:0] w_wdata, w_clrMask, w_event;
  logic [NUM_GPIO-1:0] w_level, w_rise, w_fall, w_edge;
  logic [31:0]         w_rdata;
  logic                w_unusedBits;

  assign w_word       = PADDR[APB_ADDR_WIDTH-1:2];
  assign w_access     = PSEL & PENABLE;
  assign w_write      = w_access & PWRITE;
  assign w_wdata      = PWDATA[NUM_GPIO-1:0];
  assign w_unusedBits = &{1'b0, PADDR[1:0], PWDATA};

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_WIDTH-1:0] r_dbThresh;
  logic [DB_CNT_WIDTH-1:0] r_dbCnt [NUM_GPIO];
  logic [NUM_GPIO-1:0]     w_dbHit, w_dbSat;
`else
  logic [DB_CNT_WIDTH-1:0] w_unusedDbCnt;
  assign w_unusedDbCnt = '0;
`endif

  // Read mux and address decode; unmapped offsets flag an error and read 0
  always_comb begin
    w_mapped = 1'b1;
    w_rdata  = '0;
    case (w_word)
      OFF_DIR:    w_rdata = 32'(r_dir);
      OFF_IN:     w_rdata = 32'(r_filt);
      OFF_OUT:    w_rdata = 32'(r_out);
      OFF_SET:    w_rdata = '0;
      OFF_CLR:    w_rdata = '0;
      OFF_EN:     w_rdata = 32'(r_intEn);
      OFF_TYPE:   w_rdata = 32'(r_intType);
      OFF_POL:    w_rdata = 32'(r_intPol);
      OFF_STATUS: w_rdata = 32'(r_intStatus);
`ifdef GPIO_DEBOUNCE_EN
      OFF_THRESH: w_rdata = 32'(r_dbThresh);
`endif
      default:    w_mapped = 1'b0;
    endcase
  end

  assign PREADY   = 1'b1;
  assign PSLVERR  = w_access & ~w_mapped;
  assign PRDATA   = (w_access & w_mapped) ? w_rdata : 32'h0;
  assign gpio_out = r_out;
  assign gpio_dir = r_dir;
  assign interrupt = r_irq;

  // Configuration registers; set and clear offsets modify OUT atomically
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dir     <= '0;
      r_out     <= '0;
      r_intEn   <= '0;
      r_intType <= '0;
      r_intPol  <= '0;
    end else if (w_write) begin
      case (w_word)
        OFF_DIR:  r_dir     <= w_wdata;
        OFF_OUT:  r_out     <= w_wdata;
        OFF_SET:  r_out     <= r_out | w_wdata;
        OFF_CLR:  r_out     <= r_out & ~w_wdata;
        OFF_EN:   r_intEn   <= w_wdata;
        OFF_TYPE: r_intType <= w_wdata;
        OFF_POL:  r_intPol  <= w_wdata;
        default:  ;
      endcase
    end
  end

  // Two-flop synchroniser plus the previous filtered value for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  // Debounce threshold register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dbThresh <= '0;
    end else if (w_write && (w_word == OFF_THRESH)) begin
      r_dbThresh <= PWDATA[DB_CNT_WIDTH-1:0];
    end
  end

  // Per-pin hit/saturation flags; a zero threshold hits immediately (bypass)
  always_comb begin
    w_dbHit = '0;
    w_dbSat = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      w_dbHit[i] = ({1'b0, r_dbCnt[i]} + (DB_CNT_WIDTH + 1)'(1)) >= {1'b0, r_dbThresh};
      w_dbSat[i] = &r_dbCnt[i];
    end
  end

  // Debounce counters; a 1-bit input that changes while differing becomes equal, so equality covers the restart
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_filt <= '0;
      for (int i = 0; i < NUM_GPIO; i++) r_dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_dbCnt[i] <= '0;
        end else if (w_dbHit[i]) begin
          r_filt[i]  <= r_sync2[i];
          r_dbCnt[i] <= '0;
        end else if (!w_dbSat[i]) begin
          r_dbCnt[i] <= r_dbCnt[i] + DB_CNT_WIDTH'(1);
        end
      end
    end
  end
`else
  // Filter bypassed: filtered value follows the synchroniser output
  always_ff @(posedge clk_i) begin
    if (rst_i) r_filt <= '0;
    else       r_filt <= r_sync2;
  end
`endif

  // Per-pin event: level match or polarity-selected edge of the filtered value
  always_comb begin
    w_level = ~(r_filt ^ r_intPol);
    w_rise  = r_filt & ~r_prev;
    w_fall  = ~r_filt & r_prev;
    w_edge  = (r_intPol & w_rise) | (~r_intPol & w_fall);
    w_event = (r_intType & w_edge) | (~r_intType & w_level);
    w_clrMask = (w_write && (w_word == OFF_STATUS)) ? w_wdata : '0;
  end

  // Status is W1C but a simultaneous event wins; interrupt follows one cycle later
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_intStatus <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_intStatus <= (r_intStatus & ~w_clrMask) | w_event;
      r_irq       <= |(r_intStatus & r_intEn);
    end
  end

endmodule
